uart_par_chk_gen: RTL
=====================

# uart_par_chk_gen

Parametrised UART receive parity checker. It folds a configurable-length, LSB-first data stream into a running parity and compares it with the received parity bit. It supports even, odd, mark and space parity, a frame-length check and an optional saturating error counter. It sits in the UART RX path between the bit sampler and the RX FSM, which drives its strobes.

## Interface
Parameters:
- DATA_W, 8: maximum data bits per frame; legal range 5..9.
- CNT_W, 8: error counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse; clears per-frame state; sent at the start bit.
- bit_vld  in  1  one-cycle strobe; `sampled_bit` is a data bit.
- par_vld  in  1  one-cycle strobe; `sampled_bit` is the received parity bit.
- sampled_bit  in  1  sampled serial value.
- data_len  in  $clog2(DATA_W+1)  active data bits; legal range 5..DATA_W; sampled at `frame_start`.
- PAR_EN  in  1  1 = frame carries a parity bit; sampled at `frame_start`.
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0); sampled at `frame_start`.
- cnt_clr  in  1  synchronous clear of `err_cnt`.
- par_err  out  1  parity mismatch in the current frame; held.
- len_err  out  1  wrong number of data bits before parity or frame end; held.
- frame_done  out  1  one-cycle pulse when the frame check completes.
- err_cnt  out  CNT_W  frames with `par_err` or `len_err`; saturating.

## Operation
- State machine with three states: IDLE, DATA, PAR_WAIT.
- IDLE:
  - `bit_vld` and `par_vld` are ignored.
  - `frame_start` → DATA; clears `acc`, `bit_cnt`, `par_err`, `len_err`; latches `data_len`, `PAR_EN` and `PAR_TYP`.
- DATA, on `bit_vld`:
  - `acc <= acc ^ sampled_bit`; `bit_cnt` increments.
  - When `bit_cnt+1 == data_len`: go to PAR_WAIT if the latched PAR_EN = 1. Otherwise pulse `frame_done` and go to IDLE.
- DATA, on `par_vld` (parity arrived early): `len_err <= 1`, pulse `frame_done`, go to IDLE.
- PAR_WAIT, on `bit_vld` (extra data bit): `len_err <= 1`, pulse `frame_done`, go to IDLE.
- PAR_WAIT, on `par_vld`:
  - Expected parity: `acc` (even), `~acc` (odd), 1 (mark), 0 (space).
  - `par_err <= (sampled_bit != expected)`; pulse `frame_done`; go to IDLE.
- Priority: `frame_start` beats everything, in any state. Concurrent `bit_vld`/`par_vld` in that cycle are discarded. `frame_start` mid-frame aborts the frame with no `frame_done` and no count.
- `bit_vld` and `par_vld` in the same cycle (protocol violation): treated as `par_vld` plus `len_err`.
- `bit_cnt` is DATA_W-wide safe; it never wraps because the FSM leaves DATA at `data_len`.
- `data_len` outside 5..DATA_W is unsupported; behaviour is undefined.

## Timing
- Reset values: state IDLE; `acc`, `bit_cnt`, `par_err`, `len_err`, `frame_done` = 0; `err_cnt` = 0.
- All outputs are registered.
- `par_err`/`len_err` are valid in the cycle after the strobe that sets them. They are held until the next `frame_start` (cleared in the cycle after it) or reset.
- `frame_done` rises in the same cycle `par_err`/`len_err` become valid, and lasts one cycle.
- `err_cnt` increments in the cycle after `frame_done` if `par_err|len_err`, and saturates at 2^CNT_W−1.
- `cnt_clr` beats the increment in the same cycle.
- Minimum spacing of 1 cycle between strobes; back-to-back strobes on consecutive cycles are supported.

## Configuration
- `UART_PAR_CHK_ERR_CNT_EN` defined: the counter is present as described under Timing.
- Not defined: no counter flops; `err_cnt` is tied to 0; `cnt_clr` is ignored.

## Test plan
- Even parity, data_len=8, data 0xA5 (four ones), parity bit 0 → `frame_done` pulse, `par_err`=0; parity bit 1 → `par_err`=1, `err_cnt`=1.
- Odd parity, data_len=7, data 0x13, then mark/space checks: odd parity with bit 0 → `par_err`=0. Mark with parity bit 0 → `par_err`=1. Space with parity bit 0 → `par_err`=0.
- PAR_EN=0, data_len=5, five bits → `frame_done` after the 5th `bit_vld`, no errors; a following `par_vld` in IDLE has no effect.
- Length errors, data_len=8: `par_vld` after 6 bits → `len_err`=1 and `frame_done`. In a new frame, a 9th `bit_vld` in PAR_WAIT → `len_err`=1.
- Abort and reset:
  - `frame_start` after 4 bits → no `frame_done`; the new 8-bit frame checks correctly.
  - Asserting RST mid-frame → all outputs 0, state IDLE.
- Counter (macro defined, CNT_W=2): 4 error frames → `err_cnt` saturates at 3. `cnt_clr` coincident with an increment → 0. Macro undefined → `err_cnt` stays 0.

Source files
------------

// File: rtl/uart_par_chk_gen.sv
// UART RX parity checker: folds LSB-first data bits into a running parity and checks it against the parity bit.
// Optional saturating error counter enabled by defining UART_PAR_CHK_ERR_CNT_EN.
module uart_par_chk_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          frame_start,
  input  logic                          bit_vld,
  input  logic                          par_vld,
  input  logic                          sampled_bit,
  input  logic [$clog2(DATA_W+1)-1:0]   data_len,
  input  logic                          PAR_EN,
  input  logic [1:0]                    PAR_TYP,
  input  logic                          cnt_clr,
  output logic                          par_err,
  output logic                          len_err,
  output logic                          frame_done,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int LEN_W = $clog2(DATA_W+1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_PAR_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             par_en_q, par_en_d;
  logic [1:0]       par_typ_q, par_typ_d;
  logic             par_err_q, par_err_d;
  logic             len_err_q, len_err_d;
  logic             done_q, done_d;

  // Parity bit the transmitter should have sent for the folded data parity
  function automatic logic exp_par(input logic [1:0] typ, input logic acc);
    logic res;
    case (typ)
      2'b00:   res = acc;
      2'b01:   res = ~acc;
      2'b10:   res = 1'b1;
      2'b11:   res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state and per-frame bookkeeping; frame_start overrides every strobe
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_err_d = par_err_q;
    len_err_d = len_err_q;
    done_d    = 1'b0;
    if (frame_start) begin
      state_d   = ST_DATA;
      acc_d     = 1'b0;
      bit_cnt_d = {LEN_W{1'b0}};
      par_err_d = 1'b0;
      len_err_d = 1'b0;
      len_d     = data_len;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DATA: begin
          if (par_vld) begin
            len_err_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else if (bit_vld) begin
            acc_d     = acc_q ^ sampled_bit;
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
            if ((bit_cnt_q + LEN_W'(1)) == len_q) begin
              if (par_en_q) begin
                state_d = ST_PAR_WAIT;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PAR_WAIT: begin
          if (par_vld) begin
            // A concurrent bit_vld is a protocol violation, flagged as a length error
            par_err_d = (sampled_bit != exp_par(par_typ_q, acc_q));
            len_err_d = bit_vld;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else if (bit_vld) begin
            len_err_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_PAR_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Frame state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      acc_q     <= 1'b0;
      bit_cnt_q <= {LEN_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      par_en_q  <= 1'b0;
      par_typ_q <= 2'b00;
      par_err_q <= 1'b0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_err_q <= par_err_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
    end
  end

  assign par_err    = par_err_q;
  assign len_err    = len_err_q;
  assign frame_done = done_q;

`ifdef UART_PAR_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of failed frames, sampled off the registered done pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = {CNT_W{1'b0}};
    end else if (done_q && (par_err_q || len_err_q) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign err_cnt          = {CNT_W{1'b0}};
`endif

endmodule
